reg_file: RTL and testbench

Architectural register file for the single-cycle CPU, sitting directly upstream of the ALU and driving its `a` and `b` operands. It provides 32 registers of `size` bits, with two combinational read ports, one clocked write port (ALU result or load data from writeback), and register 0 hardwired to zero. A sequenced clear engine zeroes the file on request. A debug read port gives the bench and the top level a view of the architectural state.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_read_port.sv | 32 +++
 rtl/reg_file.sv | 108 ++++++++++
 tb/tb_reg_file.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the architectural register file.
package reg_file_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    // Hardwired-zero register address and the last index the clear sweep touches.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_LAST = 5'(REG_COUNT - 1);

    // Clear engine states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: address-0 masking plus optional write bypass.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int size   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic [size-1:0]       i_regs [REG_COUNT],
    input  logic [REG_ADDR_W-1:0] i_raddr,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [size-1:0]       i_wdata,
    input  clr_state_e            i_state,
    output logic [size-1:0]       o_rdata
);

    logic w_bypass_hit;

    // A same-cycle write is forwarded only when it would actually commit.
    always_comb begin
        w_bypass_hit = BYPASS && i_we && (i_raddr == i_waddr) &&
                       (i_raddr != REG_ZERO) && (i_state == IDLE);
        if (i_raddr == REG_ZERO) begin
            o_rdata = '0;
        end else if (w_bypass_hit) begin
            o_rdata = i_wdata;
        end else begin
            o_rdata = i_regs[i_raddr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32-entry register file: two read ports, one write port, r0 hardwired to
// zero, a sequenced clear sweep and a raw (never bypassed) debug read port.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int size   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    output logic [size-1:0]       rdata_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [size-1:0]       rdata_b,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [size-1:0]       wdata,
    input  logic                  clr,
    output logic                  busy,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [size-1:0]       dbg_data
);

    // Entry 0 is never stored; it is presented as constant zero below.
    logic [size-1:0]       r_regs [1:REG_COUNT-1];
    logic [size-1:0]       w_regs [REG_COUNT];
    clr_state_e            r_state;
    logic [REG_ADDR_W-1:0] r_idx;

    // Storage, write port and clear sweep share one sequential process so the
    // sweep's zeroing and the write port can never drive the same entry twice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (we && (waddr != REG_ZERO)) begin
                        r_regs[waddr] <= wdata;
                    end
                    if (clr) begin
                        r_state <= CLEAR;
                        r_idx   <= 5'd1;
                    end
                end
                CLEAR: begin
                    r_regs[r_idx] <= '0;
                    if (r_idx == REG_LAST) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Flat view of the file with the hardwired zero in slot 0.
    always_comb begin
        w_regs[0] = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            w_regs[i] = r_regs[i];
        end
    end

    assign busy = (r_state == CLEAR);

    reg_file_read_port #(.size(size), .BYPASS(BYPASS)) u_port_a (
        .i_regs  (w_regs),
        .i_raddr (raddr_a),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_state (r_state),
        .o_rdata (rdata_a)
    );

    reg_file_read_port #(.size(size), .BYPASS(BYPASS)) u_port_b (
        .i_regs  (w_regs),
        .i_raddr (raddr_b),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_state (r_state),
        .o_rdata (rdata_b)
    );

    // Debug view shows raw stored contents only.
    reg_file_read_port #(.size(size), .BYPASS(1'b0)) u_port_dbg (
        .i_regs  (w_regs),
        .i_raddr (dbg_addr),
        .i_we    (1'b0),
        .i_waddr (REG_ZERO),
        .i_wdata ('0),
        .i_state (r_state),
        .o_rdata (dbg_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized bench for reg_file; a BYPASS=1 and a BYPASS=0
// instance share the same stimulus and are checked against one array model.
module tb_reg_file;

    logic        clk;
    logic        reset_n;
    logic [4:0]  raddr_a, raddr_b, waddr, dbg_addr;
    logic        we, clr;
    logic [31:0] wdata;

    logic [31:0] b1_rdata_a, b1_rdata_b, b1_dbg;
    logic        b1_busy;
    logic [31:0] b0_rdata_a, b0_rdata_b, b0_dbg;
    logic        b0_busy;

    int checks   = 0;
    int failures = 0;

    // Reference state: contents of r0..r31 and the sweep position (0 = no sweep,
    // otherwise the register the next edge will zero).
    logic [31:0] m_regs [32];
    int          sweep_pos;

    reg_file #(.size(32), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset_n(reset_n),
        .raddr_a(raddr_a), .rdata_a(b1_rdata_a),
        .raddr_b(raddr_b), .rdata_b(b1_rdata_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .busy(b1_busy),
        .dbg_addr(dbg_addr), .dbg_data(b1_dbg)
    );

    reg_file #(.size(32), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset_n(reset_n),
        .raddr_a(raddr_a), .rdata_a(b0_rdata_a),
        .raddr_b(raddr_b), .rdata_b(b0_rdata_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .busy(b0_busy),
        .dbg_addr(dbg_addr), .dbg_data(b0_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        sweep_pos = 0;
    endtask

    // Apply one clock edge's worth of architectural effect using pre-edge inputs.
    task automatic model_edge();
        if (sweep_pos == 0) begin
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (clr) sweep_pos = 1;
        end else begin
            m_regs[sweep_pos] = '0;
            sweep_pos = (sweep_pos == 31) ? 0 : sweep_pos + 1;
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
        if (addr == 0) return '0;
        if (byp && we && addr == waddr && sweep_pos == 0) return wdata;
        return m_regs[addr];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_busy;
        exp_busy = (sweep_pos != 0) ? 32'd1 : 32'd0;
        chk("byp_rdata_a", b1_rdata_a, exp_read(raddr_a, 1'b1));
        chk("byp_rdata_b", b1_rdata_b, exp_read(raddr_b, 1'b1));
        chk("byp_dbg",     b1_dbg,     exp_read(dbg_addr, 1'b0));
        chk("byp_busy",    {31'd0, b1_busy}, exp_busy);
        chk("nob_rdata_a", b0_rdata_a, exp_read(raddr_a, 1'b0));
        chk("nob_rdata_b", b0_rdata_b, exp_read(raddr_b, 1'b0));
        chk("nob_dbg",     b0_dbg,     exp_read(dbg_addr, 1'b0));
        chk("nob_busy",    {31'd0, b0_busy}, exp_busy);
    endtask

    // Settle combinational outputs, check, then advance one edge.
    task automatic cycle();
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0;
    endtask

    // Run a sweep already launched at T0; returns number of cycles busy was high.
    task automatic run_sweep(input bit second_clr, output int n_busy);
        n_busy = 0;
        for (int t = 1; t <= 40; t++) begin
            if (!b1_busy) break;
            n_busy++;
            idle_inputs();
            raddr_a = 5'($urandom_range(0, 31));
            raddr_b = 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            if (t == 5 && !second_clr) begin
                we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
            end
            if (t == 10 && second_clr) clr = 1'b1;
            if (t == 11) begin
                raddr_a = 5'd10; raddr_b = 5'd11; dbg_addr = 5'd20;
            end
            if (t == 21) dbg_addr = 5'd20;
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        int n_busy;

        // Reset
        idle_inputs();
        raddr_a = 5'd0; raddr_b = 5'd0; dbg_addr = 5'd0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            raddr_a = 5'($urandom_range(1, 31));
            raddr_b = 5'($urandom_range(1, 31));
            dbg_addr = 5'($urandom_range(1, 31));
            #1;
            check_all();
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Write r5, then read r5 on A and r6 on B
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        raddr_a = 5'd5; raddr_b = 5'd6; dbg_addr = 5'd5;
        cycle();
        idle_inputs();
        cycle();

        // Write to r0 is dropped
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
        raddr_a = 5'd0; raddr_b = 5'd0; dbg_addr = 5'd0;
        cycle();
        idle_inputs();
        cycle();

        // Same-cycle bypass on r7 (old value first set to something non-zero)
        we = 1'b1; waddr = 5'd7; wdata = 32'h0BAD0BAD;
        cycle();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        raddr_a = 5'd7; raddr_b = 5'd7; dbg_addr = 5'd7;
        cycle();
        idle_inputs();
        cycle();

        // Fill r1..r31 with k
        for (int k = 1; k < 32; k++) begin
            we = 1'b1; waddr = 5'(k); wdata = k;
            raddr_a = 5'(k); raddr_b = 5'($urandom_range(0, 31)); dbg_addr = 5'(k - 1);
            cycle();
        end
        idle_inputs();

        // Clear sweep with dropped write at T5
        clr = 1'b1;
        cycle();
        run_sweep(1'b0, n_busy);
        chk("sweep1_busy_cycles", n_busy, 32'd31);
        for (int k = 0; k < 32; k++) begin
            dbg_addr = 5'(k); raddr_a = 5'(k); raddr_b = 5'(31 - k);
            #1;
            chk("post_sweep_zero", b1_dbg, 32'd0);
        end
        // Write accepted right after the sweep
        we = 1'b1; waddr = 5'd9; wdata = 32'h9;
        cycle();
        idle_inputs();
        dbg_addr = 5'd9;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            clr = ($urandom_range(0, 59) == 0);
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            cycle();
        end
        idle_inputs();
        while (sweep_pos != 0) cycle();

        // Simultaneous write and clr, second clr at T10
        we = 1'b1; waddr = 5'd20; wdata = 32'h55; clr = 1'b1; dbg_addr = 5'd20;
        cycle();
        chk("r20_after_T0", b1_dbg, 32'h55);
        run_sweep(1'b1, n_busy);
        chk("sweep2_busy_cycles", n_busy, 32'd31);
        dbg_addr = 5'd20;
        #1;
        chk("r20_after_sweep", b1_dbg, 32'd0);

        // Reload some values, then asynchronous reset at T15 of a sweep
        for (int k = 1; k < 32; k++) begin
            we = 1'b1; waddr = 5'(k); wdata = $urandom | 32'h1;
            cycle();
        end
        idle_inputs();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        repeat (15) cycle();
        chk("busy_before_reset", {31'd0, b1_busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("busy_async_drop", {31'd0, b1_busy}, 32'd0);
        for (int k = 0; k < 32; k++) begin
            dbg_addr = 5'(k); raddr_a = 5'(k); raddr_b = 5'(k);
            #1;
            check_all();
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        we = 1'b1; waddr = 5'd31; wdata = 32'h1;
        raddr_a = 5'd31; dbg_addr = 5'd31;
        cycle();
        idle_inputs();
        cycle();
        chk("r31_after_reset_write", b1_dbg, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
